// File: rtl/pe_pkg.sv
// Shared PE scratchpad constants.
// Default activation width and depth used by the ifmap, filter and psum
// scratchpads, plus the derived index width.
package pe_pkg;
  localparam int unsigned PE_DATA_W = 8;
  localparam int unsigned PE_DEPTH  = 16;
  localparam int unsigned PE_IDX_W  = $clog2(PE_DEPTH);
endpackage

// File: rtl/ifmap_spad_mem.sv
// ifmap_spad_mem: 1W1R register array for the ifmap scratchpad.
// Synchronous write, asynchronous (combinational) read. Contents are not reset.
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational)
module ifmap_spad_mem
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned DEPTH  = PE_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifmap_window_spad.sv
// ifmap_window_spad: circular sliding-window ifmap scratchpad for the PE.
// Producer pushes activations via valid/ready; the MAC reads any entry by
// offset from the window base (1-cycle registered read); slide retires the
// oldest entries.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   wr_valid/wr_ready    - push handshake, wr_data is the activation
//   rd_en, rd_idx        - read request at offset rd_idx from window base
//   rd_valid, rd_data    - registered read result
//   rd_err               - 1-cycle pulse, last read had rd_idx >= count
//   slide, slide_amt     - retire min(slide_amt, count) oldest entries
//   count, empty         - occupancy
//   rd_zero              - valid read returned zero (IFMAP_SPAD_ZERO_GATE_EN)
// Macro: IFMAP_SPAD_ZERO_GATE_EN adds the registered rd_zero output.
module ifmap_window_spad
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned DEPTH  = PE_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              slide,
  input  logic [IDX_W:0]    slide_amt,
  output logic [IDX_W:0]    count,
  output logic              empty
`ifdef IFMAP_SPAD_ZERO_GATE_EN
  ,
  output logic              rd_zero
`endif
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  rd_addr;
  logic [IDX_W:0]    rel;
  logic              wr_fire;
  logic              rd_hit;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    wr_ready = (count != FULL);
    empty    = (count == '0);
    wr_fire  = wr_valid && wr_ready;
    rel      = '0;
    if (slide) rel = (slide_amt > count) ? count : slide_amt;
    rd_hit   = ({1'b0, rd_idx} < count);
    rd_addr  = base + rd_idx;
  end

  ifmap_spad_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // rel == DEPTH truncates to 0 in IDX_W bits, which is the correct base advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      base     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + IDX_W'(1);
      base  <= base + rel[IDX_W-1:0];
      count <= count + (IDX_W+1)'(wr_fire) - rel;
      rd_valid <= rd_en && rd_hit;
      rd_err   <= rd_en && !rd_hit;
      if (rd_en && rd_hit) rd_data <= mem_rdata;
    end
  end

`ifdef IFMAP_SPAD_ZERO_GATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_zero <= 1'b0;
    else     rd_zero <= rd_en && rd_hit && (mem_rdata == '0);
  end
`endif

endmodule
